// File: rtl/alu_pipe_if.sv
// Valid/ready bundle between operand-read, the execute pipe and writeback.
// The slave side is the ALU; the master side issues ops and consumes results.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_fwe;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_fwe
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_fwe
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined execute ALU: S1 captures the op, S2 computes and holds
// the result; owns the ZVN flag register, committed at output handshake.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    alu_pipe_if.slave  io,
    output logic [2:0] zvn
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int NL   = WIDTH / LANE;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB
    } op_e;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } s1_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_fwe_q, out_fwe_d;
    logic [2:0]       out_flg_q, out_flg_d;
    logic [2:0]       zvn_q, zvn_d;

    logic             s2_load;
    logic             in_ready;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             fwe;
    logic             addsub;
    logic [WIDTH:0]   sum_w;
    logic [LANE:0]    ls;
    logic [WIDTH-1:0] red;
    logic [SH_W-1:0]  sh;

    always_comb begin
        sh     = s1_q.b[SH_W-1:0];
        sum_w  = '0;
        ls     = '0;
        red    = '0;
        res    = '0;
        ovf    = 1'b0;
        fwe    = 1'b0;
        addsub = 1'b0;
        unique case (op_e'(s1_q.op))
            OP_ADD: begin
                sum_w  = {s1_q.a[WIDTH-1], s1_q.a} + {s1_q.b[WIDTH-1], s1_q.b};
                addsub = 1'b1;
                fwe    = 1'b1;
            end
            OP_SUB: begin
                sum_w  = {s1_q.a[WIDTH-1], s1_q.a} - {s1_q.b[WIDTH-1], s1_q.b};
                addsub = 1'b1;
                fwe    = 1'b1;
            end
            OP_XOR: begin
                res = s1_q.a ^ s1_q.b;
                fwe = 1'b1;
            end
            OP_RED: begin
                for (int i = 0; i < NL; i++) begin
                    red = red
                        + {{(WIDTH-LANE){s1_q.a[i*LANE+LANE-1]}}, s1_q.a[i*LANE +: LANE]}
                        + {{(WIDTH-LANE){s1_q.b[i*LANE+LANE-1]}}, s1_q.b[i*LANE +: LANE]};
                end
                res = red;
            end
            OP_SLL: begin
                res = s1_q.a << sh;
                fwe = 1'b1;
            end
            OP_SRA: begin
                res = $signed(s1_q.a) >>> sh;
                fwe = 1'b1;
            end
            OP_ROR: begin
                res = WIDTH'({s1_q.a, s1_q.a} >> sh);
                fwe = 1'b1;
            end
            OP_PADDSB: begin
                for (int i = 0; i < NL; i++) begin
                    ls = {s1_q.a[i*LANE+LANE-1], s1_q.a[i*LANE +: LANE]}
                       + {s1_q.b[i*LANE+LANE-1], s1_q.b[i*LANE +: LANE]};
                    res[i*LANE +: LANE] = (ls[LANE] != ls[LANE-1])
                        ? {ls[LANE], {(LANE-1){~ls[LANE]}}}
                        : ls[LANE-1:0];
                end
            end
            OP_LW, OP_SW: begin
                res = {s1_q.a[WIDTH-1:1], 1'b0} + {s1_q.b[WIDTH-2:0], 1'b0};
            end
            OP_LLB: begin
                res = {s1_q.a[WIDTH-1:8], s1_q.b[7:0]};
            end
            OP_LHB: begin
                res       = s1_q.a;
                res[15:8] = s1_q.b[7:0];
            end
            default: res = '0;
        endcase
        // Overflow is judged on the unsaturated sum; the result then clamps.
        if (addsub) begin
            ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
            res = ovf ? {sum_w[WIDTH], {(WIDTH-1){~sum_w[WIDTH]}}}
                      : sum_w[WIDTH-1:0];
        end
    end

    always_comb begin
        s2_load     = !out_valid_q || io.out_ready;
        in_ready    = (!s1_valid_q || s2_load) && !flush;
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_fwe_d   = out_fwe_q;
        out_flg_d   = out_flg_q;
        zvn_d       = zvn_q;
        if (in_ready) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_d = '{op: io.in_op, a: io.in_a, b: io.in_b, tag: io.in_tag};
            end
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = res;
                out_tag_d  = s1_q.tag;
                out_fwe_d  = fwe;
                out_flg_d  = {res == '0, ovf, addsub && res[WIDTH-1]};
            end
        end
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
        if (out_valid_q && io.out_ready && out_fwe_q) begin
            zvn_d = out_flg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_fwe_q   <= 1'b0;
            out_flg_q   <= '0;
            zvn_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_fwe_q   <= out_fwe_d;
            out_flg_q   <= out_flg_d;
            zvn_q       <= zvn_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_tag   = out_tag_q;
    assign io.out_fwe   = out_fwe_q;
    assign zvn          = zvn_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboarded bench for alu_pipe: accepted ops are modelled and queued,
// results are popped and compared as they leave the pipe.
module tb_alu_pipe;
    localparam int W = 16;
    localparam int L = 4;
    localparam int T = 4;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        fwe;
        logic [2:0]  flg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] zvn;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_zvn = 3'b000;
    exp_t       sb[$];
    exp_t       e;

    alu_pipe_if #(.WIDTH(W), .TAG_W(T)) io ();

    alu_pipe #(.WIDTH(W), .LANE(L), .TAG_W(T)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .io   (io),
        .zvn  (zvn)
    );

    always #5 clk = ~clk;

    function automatic int lane(input int x, input int i);
        int v;
        v = (x >> (4 * i)) & 15;
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] tag);
        exp_t m;
        int sa, sb2, ua, ub, r, sh, s;
        bit ovf;
        ua = a;
        ub = b;
        sa = a[15] ? ua - 65536 : ua;
        sb2 = b[15] ? ub - 65536 : ub;
        sh = ub & 15;
        ovf = 1'b0;
        r = 0;
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb2 : sa - sb2;
                if (r > 32767) begin r = 32767; ovf = 1'b1; end
                else if (r < -32768) begin r = -32768; ovf = 1'b1; end
            end
            4'd2: r = ua ^ ub;
            4'd3: for (int i = 0; i < 4; i++) r = r + lane(ua, i) + lane(ub, i);
            4'd4: r = ua << sh;
            4'd5: r = sa >>> sh;
            4'd6: r = (ua >> sh) | (ua << (16 - sh));
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    s = lane(ua, i) + lane(ub, i);
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    r = r | ((s & 15) << (4 * i));
                end
            end
            4'd8, 4'd9: r = (ua & 'hFFFE) + 2 * ub;
            4'd10: r = (ua & 'hFF00) | (ub & 'hFF);
            4'd11: r = ((ub & 'hFF) << 8) | (ua & 'hFF);
            default: r = 0;
        endcase
        m.data = r[15:0];
        m.tag  = tag;
        m.fwe  = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
        m.flg  = {m.data == 16'h0, ovf, (op <= 4'd1) && m.data[15]};
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_zvn = 3'b000;
        end else begin
            checks++;
            if (zvn !== exp_zvn) begin
                errors++;
                $display("FAIL zvn_track: got %b expected %b at %0t", zvn, exp_zvn, $time);
            end
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got tag %0d data %h, expected no output",
                             io.out_tag, io.out_data);
                end else begin
                    e = sb.pop_front();
                    if ({io.out_data, io.out_tag, io.out_fwe} !== {e.data, e.tag, e.fwe}) begin
                        errors++;
                        $display("FAIL sb_result: got data %h tag %0d fwe %b expected data %h tag %0d fwe %b",
                                 io.out_data, io.out_tag, io.out_fwe, e.data, e.tag, e.fwe);
                    end
                    if (e.fwe) exp_zvn = e.flg;
                end
            end
            if (flush) sb.delete();
            if (io.in_valid && io.in_ready)
                sb.push_back(model(io.in_op, io.in_a, io.in_b, io.in_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tag);
        io.in_op  = op;
        io.in_a   = a;
        io.in_b   = b;
        io.in_tag = tag;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 6;
        if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", io.out_valid); end
        if (io.out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0000", io.out_data); end
        if (io.out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag: got %h expected 0", io.out_tag); end
        if (io.out_fwe !== 1'b0) begin errors++; $display("FAIL rst_out_fwe: got %b expected 0", io.out_fwe); end
        if (zvn !== 3'b000) begin errors++; $display("FAIL rst_zvn: got %b expected 000", zvn); end
        if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", io.in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [3:0]  v_op  [7] = '{4'h1, 4'h7, 4'hB, 4'h0, 4'h9, 4'h8, 4'h6};
        logic [15:0] v_a   [7] = '{16'h0005, 16'h7770, 16'h1234, 16'h7FFF, 16'hFFFF, 16'h1001, 16'h8001};
        logic [15:0] v_b   [7] = '{16'h0005, 16'h1111, 16'h00AB, 16'h0001, 16'h0001, 16'h0004, 16'h0001};
        logic [15:0] v_res [7] = '{16'h0000, 16'h7771, 16'hAB34, 16'h7FFF, 16'h0000, 16'h1008, 16'hC000};
        logic [2:0]  v_zvn [7] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000};
        int n;
        io.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(v_op[i], v_a[i], v_b[i], 4'(i));
            io.in_valid = 1'b1;
            tick();
            io.in_valid = 1'b0;
            n = 0;
            while (!io.out_valid && n < 10) begin
                tick();
                n++;
            end
            checks += 3;
            if (!io.out_valid || n != 1) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d extra cycles expected 1", i, n);
            end
            if (io.out_data !== v_res[i]) begin
                errors++;
                $display("FAIL vec%0d_data: got %h expected %h", i, io.out_data, v_res[i]);
            end
            tick();
            if (zvn !== v_zvn[i]) begin
                errors++;
                $display("FAIL vec%0d_zvn: got %b expected %b", i, zvn, v_zvn[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n;
        io.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom_range(0, 15)), pick(), pick(), 4'(i));
            io.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (io.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL burst_in_ready%0d: got %b expected 1", i, io.in_ready);
            end
            tick();
        end
        acc = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!io.in_valid || acc) begin
                drive(4'($urandom_range(0, 15)), pick(), pick(), 4'(i));
                io.in_valid = ($urandom_range(0, 3) != 0);
            end
            io.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = io.in_valid && io.in_ready;
            tick();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_stall();
        int k, nacc, ng;
        bit in_acc, out_acc;
        logic [3:0] got [8];
        k = 1;
        nacc = 0;
        ng = 0;
        drive(4'h2, 16'(k * 16'h1111), 16'h0F0F, 4'(k));
        io.in_valid = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            io.out_ready = (cyc >= 5);
            @(negedge clk);
            in_acc = io.in_valid && io.in_ready;
            out_acc = io.out_valid && io.out_ready;
            if (in_acc) nacc++;
            if (cyc < 5 && io.out_valid) begin
                checks++;
                if (io.out_data !== 16'h1E1E || io.out_tag !== 4'd1) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%0d expected 1e1e/1", io.out_data, io.out_tag);
                end
            end
            if (cyc == 4) begin
                checks += 2;
                if (nacc != 2) begin errors++; $display("FAIL stall_accepted: got %0d expected 2", nacc); end
                if (io.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", io.in_ready); end
            end
            if (out_acc && ng < 8) begin
                got[ng] = io.out_tag;
                ng++;
            end
            tick();
            if (in_acc) begin
                k++;
                if (k > 4) io.in_valid = 1'b0;
                else drive(4'h2, 16'(k * 16'h1111), 16'h0F0F, 4'(k));
            end
        end
        checks++;
        if (ng != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d outputs expected 4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 4'(i + 1)) begin
                    errors++;
                    $display("FAIL stall_order%0d: got tag %0d expected %0d", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [2:0] saved;
        int seen;
        io.out_ready = 1'b0;
        saved = exp_zvn;
        drive(4'h2, 16'h5A5A, 16'h5A5A, 4'd5);
        io.in_valid = 1'b1;
        tick();
        drive(4'h2, 16'h5A5A, 16'h5A5A, 4'd6);
        tick();
        drive(4'h0, 16'h7FFF, 16'h7FFF, 4'd7);
        flush = 1'b1;
        @(negedge clk);
        checks += 2;
        if (io.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", io.in_ready); end
        if (io.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", io.out_valid); end
        tick();
        flush = 1'b0;
        io.in_valid = 1'b0;
        checks += 2;
        if (io.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", io.out_valid); end
        if (zvn !== saved) begin errors++; $display("FAIL flush_zvn: got %b expected %b", zvn, saved); end
        io.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (io.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_dropped: got %0d outputs expected 0", seen); end
    endtask

    task automatic test_rst_stall();
        io.out_ready = 1'b1;
        drive(4'h1, 16'h0005, 16'h0005, 4'd7);
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (zvn !== 3'b100) begin errors++; $display("FAIL rst_pre_zvn: got %b expected 100", zvn); end
        io.out_ready = 1'b0;
        drive(4'h0, 16'h0001, 16'h0001, 4'd8);
        io.in_valid = 1'b1;
        tick();
        drive(4'h0, 16'h0001, 16'h0001, 4'd9);
        tick();
        io.in_valid = 1'b0;
        tick();
        checks++;
        if (io.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", io.out_valid); end
        rst = 1'b1;
        tick();
        checks += 5;
        if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", io.out_valid); end
        if (io.out_data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", io.out_data); end
        if (io.out_tag !== 4'h0) begin errors++; $display("FAIL rstmid_tag: got %h expected 0", io.out_tag); end
        if (io.out_fwe !== 1'b0) begin errors++; $display("FAIL rstmid_fwe: got %b expected 0", io.out_fwe); end
        if (zvn !== 3'b000) begin errors++; $display("FAIL rstmid_zvn: got %b expected 000", zvn); end
        rst = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", io.out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        drive(4'h0, 16'h0, 16'h0, 4'h0);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_flush();
        test_rst_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
